// File: rtl/axi_write_sequencer.sv
// rtl/axi_write_sequencer.sv - pairs an AW mem ID with a W data word and issues one register write plus a response
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset (rst==0 resets)
//   addr_valid, addr_id      single-cycle mem ID from the address receiver
//   data_valid, data_word    single-cycle data word from the data receiver
//   wr_en, wr_id, wr_data    register write request, held until wr_ready
//   wr_ready                 register file accepts the write
//   resp_valid, resp_err     write response, held until resp_ready (err = invalid ID or timeout)
//   resp_ready               front end accepts the response
//   busy                     not collecting, or a partial pair is held
//   drop_cnt                 saturating count of discarded input words
module axi_write_sequencer #(
    parameter int                    DATA_WIDTH     = 16,
    parameter logic [DATA_WIDTH-1:0] INVALID_ID     = '1,
    parameter int                    TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  addr_valid,
    input  logic [DATA_WIDTH-1:0] addr_id,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] data_word,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_id,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_ready,
    output logic                  resp_valid,
    output logic                  resp_err,
    input  logic                  resp_ready,
    output logic                  busy,
    output logic [7:0]            drop_cnt
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CHECK   = 2'd1,
        WRITE   = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  got_addr_q, got_addr_d;
    logic                  got_data_q, got_data_d;
    logic [DATA_WIDTH-1:0] wr_id_q, wr_id_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [CW-1:0]         to_cnt_q, to_cnt_d;
    logic                  resp_err_q, resp_err_d;
    logic [7:0]            drop_cnt_q, drop_cnt_d;

    logic                  take_addr, take_data, have_addr, have_data;
    logic [1:0]            drops;
    logic [8:0]            drop_sum;

    always_comb begin
        state_d    = state_q;
        got_addr_d = got_addr_q;
        got_data_d = got_data_q;
        wr_id_d    = wr_id_q;
        wr_data_d  = wr_data_q;
        to_cnt_d   = to_cnt_q;
        resp_err_d = resp_err_q;
        take_addr  = 1'b0;
        take_data  = 1'b0;
        have_addr  = got_addr_q;
        have_data  = got_data_q;
        drops      = {1'b0, addr_valid} + {1'b0, data_valid};

        unique case (state_q)
            COLLECT: begin
                take_addr = addr_valid && !got_addr_q;
                take_data = data_valid && !got_data_q;
                have_addr = got_addr_q || take_addr;
                have_data = got_data_q || take_data;
                // Only valids for a half already held are discarded here.
                drops     = {1'b0, addr_valid && got_addr_q} + {1'b0, data_valid && got_data_q};
                if (take_addr) begin
                    wr_id_d    = addr_id;
                    got_addr_d = 1'b1;
                end
                if (take_data) begin
                    wr_data_d  = data_word;
                    got_data_d = 1'b1;
                end
                if (have_addr && have_data) begin
                    state_d = CHECK;
                end else if (got_addr_q ^ got_data_q) begin
                    // Half held and its partner did not arrive this cycle.
                    if (to_cnt_q == TO_LAST) begin
                        got_addr_d = 1'b0;
                        got_data_d = 1'b0;
                        resp_err_d = 1'b1;
                        state_d    = RESP;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end else if (take_addr || take_data) begin
                    to_cnt_d = '0;
                end
            end
            CHECK: begin
                if (wr_id_q == INVALID_ID) begin
                    resp_err_d = 1'b1;
                    state_d    = RESP;
                end else begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (wr_ready) begin
                    resp_err_d = 1'b0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    got_addr_d = 1'b0;
                    got_data_d = 1'b0;
                    resp_err_d = 1'b0;
                    state_d    = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase

        drop_sum   = {1'b0, drop_cnt_q} + {7'b0, drops};
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= COLLECT;
            got_addr_q <= 1'b0;
            got_data_q <= 1'b0;
            wr_id_q    <= '0;
            wr_data_q  <= '0;
            to_cnt_q   <= '0;
            resp_err_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            got_addr_q <= got_addr_d;
            got_data_q <= got_data_d;
            wr_id_q    <= wr_id_d;
            wr_data_q  <= wr_data_d;
            to_cnt_q   <= to_cnt_d;
            resp_err_q <= resp_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign wr_en      = (state_q == WRITE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_err_q;
    assign wr_id      = wr_id_q;
    assign wr_data    = wr_data_q;
    assign busy       = (state_q != COLLECT) || got_addr_q || got_data_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_axi_write_sequencer.sv
// tb/tb_axi_write_sequencer.sv - directed self-checking bench for axi_write_sequencer
module tb_axi_write_sequencer;

    localparam int          DW      = 16;
    localparam logic [15:0] INV_ID  = 16'h00FF;
    localparam int          TO_CYC  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          addr_valid;
    logic [DW-1:0] addr_id;
    logic          data_valid;
    logic [DW-1:0] data_word;
    logic          wr_en;
    logic [DW-1:0] wr_id;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          resp_valid;
    logic          resp_err;
    logic          resp_ready;
    logic          busy;
    logic [7:0]    drop_cnt;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    axi_write_sequencer #(
        .DATA_WIDTH     (DW),
        .INVALID_ID     (INV_ID),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr_valid (addr_valid),
        .addr_id    (addr_id),
        .data_valid (data_valid),
        .data_word  (data_word),
        .wr_en      (wr_en),
        .wr_id      (wr_id),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_ready (resp_ready),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (wr_en && resp_valid) begin
                errors++;
                $display("FAIL excl: wr_en=%b resp_valid=%b, required not both 1", wr_en, resp_valid);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        addr_valid = 1'b0;
        data_valid = 1'b0;
        addr_id    = '0;
        data_word  = '0;
    endtask

    task automatic finish_resp(input string name, input logic exp_err);
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== exp_err || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL %s_resp: valid=%b err=%b wr_en=%b, required 1 %b 0", name, resp_valid, resp_err, wr_en, exp_err);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: valid=%b busy=%b err=%b, required 0 0 0", name, resp_valid, busy, resp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; wr_ready = 1'b1; resp_ready = 1'b0;
        idle_inputs();
        step(); step();
        @(negedge clk);
        checks++;
        if ({wr_en, resp_valid, resp_err, busy} !== 4'b0 || drop_cnt !== 8'd0 || wr_id !== '0 || wr_data !== '0) begin
            errors++;
            $display("FAIL reset: wr_en=%b rv=%b err=%b busy=%b drop=%0d id=%h data=%h, required all 0",
                     wr_en, resp_valid, resp_err, busy, drop_cnt, wr_id, wr_data);
        end
        rst = 1'b1;
        step();
        mon_en = 1'b1;
    endtask

    task automatic test_split_pair();
        addr_valid = 1'b1; addr_id = 16'd3;
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL split_half: busy=%b wr_en=%b, required 1 0", busy, wr_en);
        end
        repeat (4) step();
        data_valid = 1'b1; data_word = 16'hBEEF;
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL split_check: wr_en=%b, required 0", wr_en);
        end
        step();
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1 || wr_id !== 16'd3 || wr_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL split_write: wr_en=%b id=%h data=%h, required 1 0003 beef", wr_en, wr_id, wr_data);
        end
        step();
        finish_resp("split", 1'b0);
    endtask

    task automatic test_same_cycle();
        addr_valid = 1'b1; addr_id = 16'd7;
        data_valid = 1'b1; data_word = 16'h1234;
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL same_check: wr_en=%b busy=%b, required 0 1", wr_en, busy);
        end
        step();
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1 || wr_id !== 16'd7 || wr_data !== 16'h1234) begin
            errors++;
            $display("FAIL same_write: wr_en=%b id=%h data=%h, required 1 0007 1234", wr_en, wr_id, wr_data);
        end
        step();
        finish_resp("same", 1'b0);
    endtask

    task automatic test_invalid_id();
        data_valid = 1'b1; data_word = 16'h0042;
        step();
        idle_inputs();
        addr_valid = 1'b1; addr_id = INV_ID;
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL inv_check: wr_en=%b, required 0", wr_en);
        end
        step();
        finish_resp("inv", 1'b1);
    endtask

    task automatic test_timeout();
        int early;
        addr_valid = 1'b1; addr_id = 16'd5;
        step();
        idle_inputs();
        early = 0;
        for (int i = 0; i < TO_CYC - 1; i++) begin
            step();
            @(negedge clk);
            if (resp_valid !== 1'b0 || wr_en !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL to_early: %0d cycles with output before timeout, required 0", early);
        end
        step();
        finish_resp("timeout", 1'b1);

        addr_valid = 1'b1; addr_id = 16'd5;
        step();
        idle_inputs();
        repeat (TO_CYC - 1) step();
        data_valid = 1'b1; data_word = 16'hCAFE;
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL to_rescue_check: rv=%b wr_en=%b, required 0 0", resp_valid, wr_en);
        end
        step();
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1 || wr_id !== 16'd5 || wr_data !== 16'hCAFE) begin
            errors++;
            $display("FAIL to_rescue_write: wr_en=%b id=%h data=%h, required 1 0005 cafe", wr_en, wr_id, wr_data);
        end
        step();
        finish_resp("rescue", 1'b0);
    endtask

    task automatic test_drop_saturate();
        addr_valid = 1'b1; addr_id = 16'd9;
        step();
        addr_id = 16'd10;
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (drop_cnt !== 8'd1) begin
            errors++;
            $display("FAIL dup_drop: drop_cnt=%0d, required 1", drop_cnt);
        end
        wr_ready = 1'b0;
        data_valid = 1'b1; data_word = 16'h5555;
        step();
        addr_valid = 1'b1; addr_id = 16'd11; data_word = 16'h6666;
        repeat (10) step();
        @(negedge clk);
        checks++;
        if (drop_cnt !== 8'd21) begin
            errors++;
            $display("FAIL drop_dual: drop_cnt=%0d, required 21", drop_cnt);
        end
        repeat (140) step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (drop_cnt !== 8'hFF || wr_en !== 1'b1 || wr_id !== 16'd9 || wr_data !== 16'h5555) begin
            errors++;
            $display("FAIL drop_sat: drop=%0d wr_en=%b id=%h data=%h, required 255 1 0009 5555",
                     drop_cnt, wr_en, wr_id, wr_data);
        end
        wr_ready = 1'b1;
        step();
        finish_resp("sat", 1'b0);
    endtask

    task automatic test_reset_mid_write();
        wr_ready = 1'b0;
        addr_valid = 1'b1; addr_id = 16'd2;
        data_valid = 1'b1; data_word = 16'h0F0F;
        step();
        idle_inputs();
        step();
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1) begin
            errors++;
            $display("FAIL rmw_pre: wr_en=%b, required 1", wr_en);
        end
        rst = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if ({wr_en, resp_valid, resp_err, busy} !== 4'b0 || drop_cnt !== 8'd0 || wr_id !== '0 || wr_data !== '0) begin
            errors++;
            $display("FAIL rmw_reset: wr_en=%b rv=%b err=%b busy=%b drop=%0d id=%h data=%h, required all 0",
                     wr_en, resp_valid, resp_err, busy, drop_cnt, wr_id, wr_data);
        end
        rst = 1'b1; wr_ready = 1'b1;
        addr_valid = 1'b1; addr_id = 16'd4;
        data_valid = 1'b1; data_word = 16'hA5A5;
        step();
        idle_inputs();
        step();
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1 || wr_id !== 16'd4 || wr_data !== 16'hA5A5) begin
            errors++;
            $display("FAIL rmw_fresh: wr_en=%b id=%h data=%h, required 1 0004 a5a5", wr_en, wr_id, wr_data);
        end
        step();
        finish_resp("fresh", 1'b0);
    endtask

    initial begin
        test_reset();
        test_split_pair();
        test_same_cycle();
        test_invalid_id();
        test_timeout();
        test_drop_saturate();
        test_reset_mid_write();
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
